// File: rtl/arith_unit.sv
// arith_unit: clocked 32-bit add/mul/sub/div/rem unit for the CPU datapath.
// Define ARITH_DIV_EN to build the iterative divider (opcodes 011/100).
module arith_unit #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] outau,
  output logic             out_valid,
  output logic             busy,
  output logic             div_zero,
  output logic             illegal_op
);

  if (WIDTH != 32 || DIV_CYCLES != WIDTH) begin : g_cfg_chk
    $error("arith_unit: only WIDTH = DIV_CYCLES = 32 is supported");
  end

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_DIV = 3'b011,
    OP_REM = 3'b100
  } op_e;

  logic             issue;
  logic             op_add;
  logic             op_mul;
  logic             op_sub;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH-1:0] outau_q, outau_d;
  logic             vld_q, vld_d;
  logic             ill_q, ill_d;

  assign issue  = in_valid & ~busy;
  assign op_add = (opcode == OP_ADD);
  assign op_mul = (opcode == OP_MUL);
  assign op_sub = (opcode == OP_SUB);
  assign mul_lo = a * b;

`ifdef ARITH_DIV_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             dz_q, dz_d;
  logic             op_div;
  logic             op_rem;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   dif;

  assign op_div   = (opcode == OP_DIV);
  assign op_rem   = (opcode == OP_REM);
  assign busy     = (state_q == S_DIV);
  assign div_zero = dz_q;

  // Quotient bits shift into the dividend register, MSB first.
  assign shf = {rem_q, dvd_q[WIDTH-1]};
  assign dif = shf - {1'b0, dvs_q};
`else
  assign busy     = 1'b0;
  assign div_zero = 1'b0;
`endif

  always_comb begin
    outau_d = outau_q;
    vld_d   = 1'b0;
    ill_d   = ill_q;
`ifdef ARITH_DIV_EN
    dz_d     = dz_q;
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
`endif
    if (issue) begin
      vld_d = 1'b1;
      ill_d = 1'b0;
`ifdef ARITH_DIV_EN
      dz_d  = 1'b0;
`endif
      unique case (1'b1)
        op_add: outau_d = a + b;
        op_mul: outau_d = mul_lo;
        op_sub: outau_d = a - b;
`ifdef ARITH_DIV_EN
        op_div, op_rem: begin
          if (b == '0) begin
            dz_d    = 1'b1;
            outau_d = op_div ? '1 : a;
          end else begin
            vld_d    = 1'b0;
            state_d  = S_DIV;
            dvd_d    = a;
            dvs_d    = b;
            rem_d    = '0;
            cnt_d    = '0;
            is_rem_d = op_rem;
          end
        end
`endif
        default: begin
          outau_d = '0;
          ill_d   = 1'b1;
        end
      endcase
    end
`ifdef ARITH_DIV_EN
    else if (state_q == S_DIV) begin
      if (cnt_q == CW'(DIV_CYCLES)) begin
        outau_d = is_rem_q ? rem_q : dvd_q;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        rem_d = dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~dif[WIDTH]};
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outau_q <= '0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      outau_q <= outau_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
    end
  end

`ifdef ARITH_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      dz_q     <= dz_d;
    end
  end
`endif

  assign outau      = outau_q;
  assign out_valid  = vld_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: directed table, hand sequences and random ops vs a model.
// Honours ARITH_DIV_EN the same way the design does.
module tb_arith_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  opcode;
  logic        in_valid;
  logic [31:0] outau;
  logic        out_valid;
  logic        busy;
  logic        div_zero;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  arith_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .in_valid   (in_valid),
    .outau      (outau),
    .out_valid  (out_valid),
    .busy       (busy),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  op;
    logic [31:0] res;
    logic        dz;
    logic        ill;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                              input logic [2:0] op, input logic [31:0] res,
                              input logic dz, input logic ill,
                              input int lat, input string nm);
    vec_t v;
    v.va = va; v.vb = vb; v.op = op; v.res = res;
    v.dz = dz; v.ill = ill; v.lat = lat; v.nm = nm;
    return v;
  endfunction

  // Reference: results from plain arithmetic on the operation's definition.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [2:0] op,
                                output logic [31:0] r, output logic dz,
                                output logic ill, output int lat);
    longint unsigned p;
    r = 0; dz = 0; ill = 0; lat = 1;
    case (op)
      3'd0: begin p = longint'(x) + longint'(y); r = p[31:0]; end
      3'd1: begin p = longint'(x) * longint'(y); r = p[31:0]; end
      3'd2: begin p = longint'(x) - longint'(y); r = p[31:0]; end
      3'd3, 3'd4: begin
`ifdef ARITH_DIV_EN
        if (y == 0) begin
          dz = 1;
          r  = (op == 3'd3) ? 32'hFFFF_FFFF : x;
        end else begin
          r   = (op == 3'd3) ? x / y : x % y;
          lat = 33;
        end
`else
        ill = 1;
`endif
      end
      default: ill = 1;
    endcase
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [2:0] top, input string nm,
                        input logic [31:0] eres, input logic edz,
                        input logic eill, input int elat);
    int cyc;
    int busy_bad;
    bit got;
    cyc = 0; busy_bad = 0; got = 0;
    @(negedge clk);
    a = ta; b = tb2; opcode = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; opcode = 3'($urandom);
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) got = 1;
      else if (busy !== (elat > 1)) busy_bad++;
    end
    chk({nm, "_lat"}, cyc, elat);
    chk({nm, "_res"}, outau, eres);
    chk({nm, "_dz"}, 32'(div_zero), 32'(edz));
    chk({nm, "_ill"}, 32'(illegal_op), 32'(eill));
    chk({nm, "_busy_done"}, 32'(busy), 0);
    chk({nm, "_busy_wait"}, busy_bad, 0);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic [2:0]  rop;
    logic        edz, eill;
    int          elat;
    int          bad;
    int          cyc;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
    #12;
    chk("rst_outau", outau, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dz", 32'(div_zero), 0);
    chk("rst_ill", 32'(illegal_op), 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(10, 5, 3'b000, 15, 0, 0, 1, "add"));
    vecs.push_back(mk(10, 5, 3'b001, 50, 0, 0, 1, "mul"));
    vecs.push_back(mk(10, 5, 3'b010, 5, 0, 0, 1, "sub"));
    vecs.push_back(mk(0, 1, 3'b010, 32'hFFFF_FFFF, 0, 0, 1, "sub_wrap"));
    vecs.push_back(mk(32'hFFFF_FFFF, 1, 3'b000, 0, 0, 0, 1, "add_carry"));
    vecs.push_back(mk(32'h0001_0000, 32'h0001_0000, 3'b001, 0, 0, 0, 1,
                      "mul_trunc"));
    vecs.push_back(mk(10, 5, 3'b110, 0, 0, 1, 1, "ill_110"));
    vecs.push_back(mk(1, 2, 3'b101, 0, 0, 1, 1, "ill_101"));
    vecs.push_back(mk(3, 4, 3'b111, 0, 0, 1, 1, "ill_111"));
`ifdef ARITH_DIV_EN
    vecs.push_back(mk(10, 5, 3'b011, 2, 0, 0, 33, "div"));
    vecs.push_back(mk(10, 3, 3'b100, 1, 0, 0, 33, "rem"));
    vecs.push_back(mk(10, 3, 3'b011, 3, 0, 0, 33, "div3"));
    vecs.push_back(mk(7, 0, 3'b011, 32'hFFFF_FFFF, 1, 0, 1, "div0"));
    vecs.push_back(mk(7, 0, 3'b100, 7, 1, 0, 1, "rem0"));
    vecs.push_back(mk(32'hFFFF_FFFF, 1, 3'b011, 32'hFFFF_FFFF, 0, 0, 33,
                      "div_max"));
    vecs.push_back(mk(5, 32'hFFFF_FFFF, 3'b100, 5, 0, 0, 33, "rem_big"));
`else
    vecs.push_back(mk(10, 5, 3'b011, 0, 0, 1, 1, "nodiv_div"));
    vecs.push_back(mk(10, 3, 3'b100, 0, 0, 1, 1, "nodiv_rem"));
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].op, vecs[i].nm,
             vecs[i].res, vecs[i].dz, vecs[i].ill, vecs[i].lat);

    // Back-to-back single-cycle issues.
    @(negedge clk);
    a = 10; b = 5; opcode = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_add", outau, 15);
    chk("b2b_v0", 32'(out_valid), 1);
    opcode = 3'b001;
    @(negedge clk);
    chk("b2b_mul", outau, 50);
    chk("b2b_v1", 32'(out_valid), 1);
    opcode = 3'b010;
    @(negedge clk);
    chk("b2b_sub", outau, 5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drop", 32'(out_valid), 0);

`ifdef ARITH_DIV_EN
    // Issues while busy are ignored; one held across busy falling is taken.
    @(negedge clk);
    a = 100; b = 7; opcode = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 1; b = 1; opcode = 3'b000;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_lat", cyc, 33);
    chk("ign_res", outau, 14);
    chk("ign_busy", 32'(busy), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fall_issue_v", 32'(out_valid), 1);
    chk("fall_issue_res", outau, 2);
`endif

    // Reset in the middle of a long operation.
    run_op(3, 4, 3'b000, "pre_rst", 7, 0, 0, 1);
    @(negedge clk);
    a = 1000; b = 3; opcode = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outau", outau, 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dz", 32'(div_zero), 0);
    chk("mid_rst_ill", 32'(illegal_op), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);
    run_op(2, 3, 3'b000, "post_rst_add", 5, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rop = 3'($urandom_range(0, 7));
      model(ra, rb, rop, er, edz, eill, elat);
      run_op(ra, rb, rop, $sformatf("rnd%0d_op%0d", i, rop),
             er, edz, eill, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
